// File: rtl/cflog_wr_arbiter.sv
// CFLog write-port arbiter: serialises branch, loop and SpecCFA entries
// into the log, tracks the write pointer and requests a flush when full.
module cflog_wr_arbiter #(
  parameter logic [15:0] LOG_SIZE = 16'h0100
) (
  input  logic        clk,
  input  logic        puc,
  input  logic        br_req,
  input  logic [15:0] br_src,
  input  logic [15:0] br_dest,
  output logic        br_gnt,
  input  logic        loop_req,
  input  logic [31:0] loop_ctr,
  output logic        loop_gnt,
  input  logic        spec_req,
  input  logic [15:0] spec_id,
  output logic        spec_gnt,
  input  logic        flush_force,
  input  logic        flush_ack,
  output logic        log_wen,
  output logic [15:0] log_wdata,
  output logic [15:0] log_ptr,
  output logic        flush_req,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR0,
    S_WR1,
    S_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BR,
    SRC_LOOP,
    SRC_SPEC
  } src_t;

  state_t      r_state;
  src_t        r_src;
  logic [15:0] r_w0;
  logic [15:0] r_w1;
  logic        r_two;
  logic [15:0] r_ptr;

  logic [16:0] w_cap;
  logic [16:0] w_need1;
  logic [16:0] w_need2;
  logic        w_fit1;
  logic        w_fit2;

  // 17-bit sums so a pointer at the top of the range cannot wrap
  assign w_cap   = {1'b0, LOG_SIZE};
  assign w_need1 = {1'b0, r_ptr} + 17'd1;
  assign w_need2 = {1'b0, r_ptr} + 17'd2;
  assign w_fit1  = (w_need1 <= w_cap);
  assign w_fit2  = (w_need2 <= w_cap);

  always_ff @(posedge clk or posedge puc) begin
    if (puc) begin
      r_state <= S_IDLE;
      r_src   <= SRC_NONE;
      r_w0    <= '0;
      r_w1    <= '0;
      r_two   <= 1'b0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (flush_force) begin
            r_state <= S_FLUSH;
          end else if (br_req) begin
            if (!w_fit2) begin
              r_state <= S_FLUSH;
            end else begin
              r_w0    <= br_src;
              r_w1    <= br_dest;
              r_two   <= 1'b1;
              r_src   <= SRC_BR;
              r_state <= S_WR0;
            end
          end else if (loop_req) begin
            if (!w_fit2) begin
              r_state <= S_FLUSH;
            end else begin
              r_w0    <= loop_ctr[31:16];
              r_w1    <= loop_ctr[15:0];
              r_two   <= 1'b1;
              r_src   <= SRC_LOOP;
              r_state <= S_WR0;
            end
          end else if (spec_req) begin
            if (!w_fit1) begin
              r_state <= S_FLUSH;
            end else begin
              r_w0    <= spec_id;
              r_w1    <= '0;
              r_two   <= 1'b0;
              r_src   <= SRC_SPEC;
              r_state <= S_WR0;
            end
          end
        end
        S_WR0: begin
          r_ptr   <= r_ptr + 16'd1;
          r_state <= r_two ? S_WR1 : S_IDLE;
        end
        S_WR1: begin
          r_ptr   <= r_ptr + 16'd1;
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          if (flush_ack) begin
            r_ptr   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    log_wen   = 1'b0;
    log_wdata = '0;
    br_gnt    = 1'b0;
    loop_gnt  = 1'b0;
    spec_gnt  = 1'b0;
    flush_req = 1'b0;
    unique case (r_state)
      S_WR0: begin
        log_wen   = 1'b1;
        log_wdata = r_w0;
        spec_gnt  = (r_src == SRC_SPEC);
      end
      S_WR1: begin
        log_wen   = 1'b1;
        log_wdata = r_w1;
        br_gnt    = (r_src == SRC_BR);
        loop_gnt  = (r_src == SRC_LOOP);
      end
      S_FLUSH: flush_req = 1'b1;
      default: ;
    endcase
  end

  assign log_ptr = r_ptr;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: doc/cflog_wr_arbiter.md
Name: cflog_wr_arbiter

Overview:
- Owns the single CFLog write port and shares it between three hardware requesters: branch logger (src/dest pair), loop logger (32-bit counter), and SpecCFA block-ID writer.
- Sequences multi-word entries atomically and maintains the log write pointer.
- When an entry will not fit, or on a forced flush, it raises a flush request toward the TCB. It resets the pointer on acknowledge.
- Sits between the logger/loop/SpecCFA monitors and the CFLog memory inside cflow.

Parameters:
LOG_SIZE, 16'h0100, log capacity in 2-byte words (must be >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
puc  input  1  reset, asynchronous, active-high
br_req  input  1  branch entry pending; held high until br_gnt
br_src  input  16  branch source address
br_dest  input  16  branch destination address
br_gnt  output  1  one-cycle pulse, branch entry fully written
loop_req  input  1  loop-counter entry pending; held until loop_gnt
loop_ctr  input  32  loop iteration count
loop_gnt  output  1  one-cycle pulse, loop entry fully written
spec_req  input  1  SpecCFA block-ID entry pending; held until spec_gnt
spec_id  input  16  speculated block identifier
spec_gnt  output  1  one-cycle pulse, spec entry written
flush_force  input  1  level; request flush at next idle (ER_done/boot)
flush_ack  input  1  TCB has consumed the log
log_wen  output  1  CFLog write strobe
log_wdata  output  16  CFLog write data
log_ptr  output  16  word index of next write (0..LOG_SIZE)
flush_req  output  1  log must be drained; held until flush_ack
busy  output  1  state != IDLE

Behaviour:
- Reset: puc=1 forces state IDLE, log_ptr=0, holding regs=0. All outputs are 0 while reset is asserted and immediately after. puc mid-entry abandons the entry with no gnt; the requester still holds req and is re-served after reset.
- States: IDLE, WR0, WR1, FLUSH. All outputs are decoded from registered state/holding regs (Moore); there are no combinational paths from inputs to outputs.
- IDLE priority, evaluated each cycle:
  1. flush_force -> FLUSH.
  2. br_req (2 words).
  3. loop_req (2 words).
  4. spec_req (1 word).
- Space check: entry needs N words. If log_ptr + N > LOG_SIZE, go to FLUSH and leave the request pending. Otherwise latch the data into the holding regs, record the source, and go to WR0.
- Word order:
  - branch: W0=br_src, W1=br_dest.
  - loop: W0=loop_ctr[31:16], W1=loop_ctr[15:0].
  - spec: W0=spec_id.
- WR0: log_wen=1, log_wdata=W0, log_ptr increments by 1 at the edge leaving WR0. A 2-word entry goes to WR1. A 1-word entry asserts spec_gnt=1 in this cycle and returns to IDLE.
- WR1: log_wen=1, log_wdata=W1, the gnt for the source =1, log_ptr +1, then IDLE.
- Latency: a req seen in IDLE at cycle t gives the first log_wen at t+1. A 2-word entry gnts at t+2, a 1-word entry at t+1. Minimum gap between entries is 1 IDLE cycle.
- Requester rule: req must be low in the cycle after gnt. A req registered-deasserted off gnt satisfies this. Data need not be held after the IDLE latch cycle.
- Entries are never split across a flush; an entry is always contiguous.
- FLUSH: flush_req=1, log_wen=0, no gnt. On flush_ack=1, log_ptr<=0 and go to IDLE; flush_req falls the next cycle. flush_ack outside FLUSH is ignored.
- flush_force is level-sensitive. It re-triggers FLUSH from every IDLE cycle while high, so the source must drop it by flush_ack.
- log_ptr never exceeds LOG_SIZE. log_ptr==LOG_SIZE is legal (full); any request then flushes first.
- Requests arriving during WR0/WR1/FLUSH wait; no req is dropped. Fixed priority may starve spec under continuous br traffic; this is accepted.

Test Plan:
1. Single branch entry: ptr=0, br_req with src=16'hE100, dest=16'hE200 -> log_wen 2 cycles with data E100 then E200, br_gnt in the 2nd cycle, log_ptr=2.
2. Simultaneous br_req, loop_req (ctr=32'h0001_0002), spec_req (id=16'h0007) at ptr=0 -> order branch (ptr 0-1), loop writes 0001, 0002 (ptr 2-3), spec writes 0007 (ptr 4). Each gnt fires exactly once; final log_ptr=5.
3. Fit boundary, LOG_SIZE=4, ptr=3:
   - spec_req written at ptr 3 -> ptr=4.
   - Then br_req -> FLUSH, flush_req=1, no log_wen.
   - flush_ack -> ptr=0, then branch written at 0-1.
4. ptr=3 with LOG_SIZE=4 and br_req -> FLUSH immediately; the 1-word gap is left unused.
5. flush_force pulse at ptr=2 while idle -> FLUSH. flush_ack held low 10 cycles keeps flush_req high. Ack then gives ptr=0, flush_req low the next cycle.
6. puc asserted during WR1 of a loop entry -> outputs 0, ptr=0, no loop_gnt. After release, the held loop_req is rewritten from ptr 0 with a correct gnt.
